// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle controller and the MIPS datapath.
// The controller drives the control word. The datapath supplies the IR fields and the ALU zero flag.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;

  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;

  // The controller only needs the opcode. The datapath consumes funct in the ALU decoder.
  // The datapath also combines zero with pc_write_cond to form the PC load.
  modport master (
    input  opcode,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM. It sequences fetch, decode, execute, memory access and writeback.
// The FSM advances only on edges where step_en is high, which allows single-step operation.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              step_en,
  multicycle_ctrl_if.master bus,
  output logic [3:0]        state,
  output logic              instr_done,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_q;
  state_t state_d;
  logic   op_legal;
  logic   retire_state;
  logic   wr_gate;

  // Ungated Moore control word
  logic       pc_write_m;
  logic       pc_write_cond_m;
  logic       mem_write_m;
  logic       ir_write_m;
  logic       reg_write_m;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: use non-blocking (<=) for every register. All flops then update together at the edge,
  // so the order of the blocks in the simulator cannot change the result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else if (step_en) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    op_legal = 1'b0;
    case (bus.opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: assign a default to every always_comb output before the case statement.
  // If any path leaves an output unassigned, synthesis infers a latch.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      // The IR is held from FETCH onward, so the opcode here is still the one from DECODE.
      S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write_m      = 1'b0;
    pc_write_cond_m = 1'b0;
    mem_write_m     = 1'b0;
    ir_write_m      = 1'b0;
    reg_write_m     = 1'b0;
    bus.iord        = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.alu_op      = 2'b00;
    bus.pc_source   = 2'b00;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        ir_write_m    = 1'b1;
        pc_write_m    = 1'b1;
        bus.alu_src_b = 2'b01;
      end
      S_DECODE: bus.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write_m    = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write_m = 1'b1;
        bus.iord    = 1'b1;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write_m = 1'b1;
        bus.reg_dst = 1'b1;
      end
      S_ADDIWB: reg_write_m = 1'b1;
      S_BRANCH: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_op      = 2'b01;
        pc_write_cond_m = 1'b1;
        bus.pc_source   = 2'b01;
      end
      S_JUMP: begin
        pc_write_m    = 1'b1;
        bus.pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  // A stalled or resetting cycle must never commit architectural state.
  // The mux selects stay valid because they have no effect when nothing is written.
  assign wr_gate           = step_en & ~reset;
  assign bus.pc_write      = pc_write_m      & wr_gate;
  assign bus.pc_write_cond = pc_write_cond_m & wr_gate;
  assign bus.mem_write     = mem_write_m     & wr_gate;
  assign bus.ir_write      = ir_write_m      & wr_gate;
  assign bus.reg_write     = reg_write_m     & wr_gate;

  // ---------------------------------------------------------------------------
  // Retire / illegal-opcode pulses and retired-instruction counter
  // ---------------------------------------------------------------------------
  always_comb begin
    retire_state = 1'b0;
    case (state_q)
      S_MEMWB, S_MEMWR, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: retire_state = 1'b1;
      default: retire_state = 1'b0;
    endcase
  end

  assign instr_done = retire_state & wr_gate;
  assign illegal_op = (state_q == S_DECODE) & ~op_legal & wr_gate;

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_count <= '0;
    end else if (instr_done) begin
      instr_count <= instr_count + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. It runs directed instruction sequences and then a random mix.
// A path and control-word reference model built from the instruction latencies checks every cycle.
module tb_multicycle_ctrl;
  localparam int CW = 10;  // narrow counter keeps the wrap test short

  typedef int int_q_t[$];

  logic           clock = 1'b0;
  logic           reset;
  logic           step_en;
  logic [3:0]     state;
  logic           instr_done;
  logic           illegal_op;
  logic [CW-1:0]  instr_count;
  logic [CW-1:0]  model_count;
  logic [15:0]    obs_ctrl;
  int             passes = 0;
  int             checks = 0;

  always #5 clock = ~clock;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .step_en     (step_en),
    .bus         (bus),
    .state       (state),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  assign obs_ctrl = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                     bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                     bus.alu_src_b, bus.alu_op, bus.pc_source};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Control word the table prescribes for a state; write enables only count when en is high.
  function automatic logic [15:0] exp_ctrl(input int st, input bit en);
    logic pw = 0, pwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, asa = 0;
    logic [1:0] asb = 0, aop = 0, psrc = 0;
    case (st)
      0:       begin mr = 1; irw = 1; pw = 1; asb = 2'b01; end
      1:       asb = 2'b11;
      2, 10:   begin asa = 1; asb = 2'b10; end
      3:       begin mr = 1; iord = 1; end
      4:       begin rw = 1; m2r = 1; end
      5:       begin mw = 1; iord = 1; end
      6:       begin asa = 1; aop = 2'b10; end
      7:       begin rw = 1; rd = 1; end
      11:      rw = 1;
      8:       begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      9:       begin pw = 1; psrc = 2'b10; end
      default: ;
    endcase
    return {pw & en, pwc & en, iord, mr, mw & en, irw & en, m2r, rd, rw & en, asa,
            asb, aop, psrc};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  // Each instruction passes FETCH and DECODE, then follows its own execution path.
  function automatic int_q_t path_of(input logic [5:0] op);
    int_q_t q;
    q = '{0, 1};
    case (op)
      6'b100011: q = '{0, 1, 2, 3, 4};  // lw   : 5 steps
      6'b101011: q = '{0, 1, 2, 5};     // sw   : 4 steps
      6'b000000: q = '{0, 1, 6, 7};     // R    : 4 steps
      6'b001000: q = '{0, 1, 10, 11};   // addi : 4 steps
      6'b000100: q = '{0, 1, 8};        // beq  : 3 steps
      6'b000010: q = '{0, 1, 9};        // j    : 3 steps
      default:   ;
    endcase
    return q;
  endfunction

  // Run one clock cycle. Starting at the negedge, drive the inputs, check all outputs before the edge,
  // take the edge and update the model.
  task automatic step_cycle(input int exp_st, input bit se, input bit rst,
                            input bit exp_done, input bit exp_ill);
    step_en = se;
    reset   = rst;
    #1;
    check("state", 32'(state), 32'(exp_st));
    check($sformatf("ctrl@%0d", exp_st), 32'(obs_ctrl), 32'(exp_ctrl(exp_st, se && !rst)));
    check("instr_done", 32'(instr_done), 32'(exp_done));
    check("illegal_op", 32'(illegal_op), 32'(exp_ill));
    check("instr_count", 32'(instr_count), 32'(model_count));
    @(posedge clock);
    if (rst)           model_count = '0;
    else if (exp_done) model_count = model_count + 1'b1;
    @(negedge clock);
  endtask

  task automatic run_instr(input logic [5:0] op, input bit z, input bit stalls);
    int_q_t q;
    bit     legal;
    q     = path_of(op);
    legal = is_legal(op);
    bus.opcode = op;
    bus.zero   = z;
    bus.funct  = 6'($urandom);
    foreach (q[i]) begin
      if (stalls && $urandom_range(0, 4) == 0)
        step_cycle(q[i], 1'b0, 1'b0, 1'b0, 1'b0);
      step_cycle(q[i], 1'b1, 1'b0, legal && (i == q.size() - 1), !legal && (q[i] == 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [5:0] legal_ops [6];
    logic [5:0] op;
    legal_ops   = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    model_count = '0;
    reset       = 1'b1;
    step_en     = 1'b0;
    bus.opcode  = 6'd0;
    bus.funct   = 6'd0;
    bus.zero    = 1'b0;

    // Reset for two cycles. The second cycle has step_en high, but reset must still gate every write.
    @(posedge clock);
    @(negedge clock);
    step_cycle(0, 1'b1, 1'b1, 1'b0, 1'b0);

    run_instr(6'b100011, 1'b0, 1'b0);  // lw
    run_instr(6'b000100, 1'b1, 1'b0);  // beq taken
    run_instr(6'b000100, 1'b0, 1'b0);  // beq not taken
    run_instr(6'b111111, 1'b0, 1'b0);  // illegal

    // R-type, stall in EXEC for 3 cycles, then reset while in RWB
    bus.opcode = 6'b000000;
    step_cycle(0, 1'b1, 1'b0, 1'b0, 1'b0);
    step_cycle(1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step_cycle(6, 1'b0, 1'b0, 1'b0, 1'b0);
    step_cycle(6, 1'b1, 1'b0, 1'b0, 1'b0);
    step_cycle(7, 1'b1, 1'b1, 1'b0, 1'b0);
    check("count_after_reset", 32'(instr_count), 32'd0);

    // Random instruction mix with occasional stalls
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(op, 1'($urandom), 1'b1);
    end

    // Run j instructions until the counter reaches all-ones, then retire one more so it wraps
    while (model_count != '1) run_instr(6'b000010, 1'b0, 1'b0);
    check("count_all_ones", 32'(instr_count), 32'((1 << CW) - 1));
    run_instr(6'b000010, 1'b0, 1'b0);
    step_en = 1'b0;
    #1;
    check("count_wrapped", 32'(instr_count), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
